// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift-unit issue stage: funct codes, shifter ops, entry layout.
package shift_issue_stage_pkg;

  localparam int unsigned ENTRY_DW = 32;
  localparam int unsigned ENTRY_SW = 5;

  // R-type funct codes of the six shift instructions
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;

  // Barrel shifter operation codes
  localparam logic [1:0] SHT_NONE   = 2'b00;
  localparam logic [1:0] SHT_LEFT   = 2'b01;
  localparam logic [1:0] SHT_LRIGHT = 2'b10;
  localparam logic [1:0] SHT_ARIGHT = 2'b11;

  typedef struct packed {
    logic [ENTRY_DW-1:0] da;
    logic [ENTRY_SW-1:0] db;
    logic [1:0]          func;
    logic [4:0]          rd;
    logic                is_shift;
  } entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an R-type shift instruction into a shifter operand entry.
module shift_decode
  import shift_issue_stage_pkg::*;
(
  input  logic [31:0]         instr_i,
  input  logic [ENTRY_DW-1:0] rs_data_i,
  input  logic [ENTRY_DW-1:0] rt_data_i,
  output entry_t              entry_o
);

  logic [5:0] funct;
  logic [4:0] shamt;
  logic       unused_bits;

  assign funct = instr_i[5:0];
  assign shamt = instr_i[10:6];
  // rs/rt register fields are resolved upstream; only forwarded data is used here
  assign unused_bits = ^{instr_i[25:16], rs_data_i[ENTRY_DW-1:ENTRY_SW]};

  // Map funct to shifter op and amount source; anything else passes through as a no-op
  always_comb begin
    entry_o    = '0;
    entry_o.rd = instr_i[15:11];
    if (instr_i[31:26] == 6'b0) begin
      unique case (funct)
        FN_SLL:  begin entry_o.func = SHT_LEFT;   entry_o.db = shamt;                 end
        FN_SRL:  begin entry_o.func = SHT_LRIGHT; entry_o.db = shamt;                 end
        FN_SRA:  begin entry_o.func = SHT_ARIGHT; entry_o.db = shamt;                 end
        FN_SLLV: begin entry_o.func = SHT_LEFT;   entry_o.db = rs_data_i[ENTRY_SW-1:0]; end
        FN_SRLV: begin entry_o.func = SHT_LRIGHT; entry_o.db = rs_data_i[ENTRY_SW-1:0]; end
        FN_SRAV: begin entry_o.func = SHT_ARIGHT; entry_o.db = rs_data_i[ENTRY_SW-1:0]; end
        default: ;
      endcase
      if (entry_o.func != SHT_NONE) begin
        entry_o.is_shift = 1'b1;
        entry_o.da       = rt_data_i;
      end
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// ID/EX issue stage for the shift unit: decode, two-entry skid buffer, stall counter.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned DW    = ENTRY_DW,
  parameter int unsigned SW    = ENTRY_SW,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [DW-1:0]    rs_data,
  input  logic [DW-1:0]    rt_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    SHT_DA,
  output logic [SW-1:0]    SHT_DB,
  output logic [1:0]       SHT_Func,
  output logic [4:0]       out_rd,
  output logic             out_is_shift,
  output logic [CNT_W-1:0] stall_cnt
);

  entry_t           dec_entry;
  entry_t           main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             accept, pop;

  shift_decode u_decode (
    .instr_i   (instr),
    .rs_data_i (rs_data),
    .rt_data_i (rt_data),
    .entry_o   (dec_entry)
  );

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid_q & out_ready;

  // Skid-buffer routing; flush only drops valid bits so outputs keep their last data
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      // in_ready is low here, so no accept can collide with the skid drain
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || pop)) begin
      main_d       = dec_entry;
      main_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end

  // Saturating count of cycles where a valid entry is held back
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign SHT_DA       = main_q.da;
  assign SHT_DB       = main_q.db;
  assign SHT_Func     = main_q.func;
  assign out_rd       = main_q.rd;
  assign out_is_shift = main_q.is_shift;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

  typedef struct packed {
    logic [31:0] da;
    logic [4:0]  db;
    logic [1:0]  fn;
    logic [4:0]  rd;
    logic        sh;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] SHT_DA;
  logic [4:0]  SHT_DB;
  logic [1:0]  SHT_Func;
  logic [4:0]  out_rd;
  logic        out_is_shift;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  shift_issue_stage #(.DW(32), .SW(5), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .SHT_DA       (SHT_DA),
    .SHT_DB       (SHT_DB),
    .SHT_Func     (SHT_Func),
    .out_rd       (out_rd),
    .out_is_shift (out_is_shift),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa,
                                       input logic [5:0] fn);
    return {6'b0, rs, rt, rd, sa, fn};
  endfunction

  // Reference decode straight from the instruction table
  function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] rs,
                                        input logic [31:0] rt);
    exp_t e;
    logic [4:0] sa;
    sa = i[10:6];
    e = '0;
    e.rd = i[15:11];
    if (i[31:26] == 6'd0) begin
      case (i[5:0])
        6'd0: begin e.fn = 2'd1; e.db = sa; end
        6'd2: begin e.fn = 2'd2; e.db = sa; end
        6'd3: begin e.fn = 2'd3; e.db = sa; end
        6'd4: begin e.fn = 2'd1; e.db = rs[4:0]; end
        6'd6: begin e.fn = 2'd2; e.db = rs[4:0]; end
        6'd7: begin e.fn = 2'd3; e.db = rs[4:0]; end
        default: e.fn = 2'd0;
      endcase
      if (e.fn != 2'd0) begin
        e.sh = 1'b1;
        e.da = rt;
      end
    end
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_hs: ready/valid=%b required 10", {in_ready, out_valid});
    end
    n_cmp++;
    if ({SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift, stall_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_data: da=%h db=%0d fn=%b rd=%0d sh=%b cnt=%0d required all 0",
               SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift, stall_cnt);
    end
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_after_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_sll();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h0009_4100;
    rs_data   = 32'h0;
    rt_data   = 32'h0000_000F;
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift} !==
        {1'b1, 32'h0000_000F, 5'd4, 2'b01, 5'd8, 1'b1}) begin
      n_err++;
      $display("FAIL sll: v=%b da=%h db=%0d fn=%b rd=%0d sh=%b required 1 0000000f 4 01 8 1",
               out_valid, SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift);
    end
    cyc();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sll_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_srav();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h016C_5007;
    rs_data   = 32'h0000_0023;
    rt_data   = 32'h8000_0000;
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift} !==
        {1'b1, 32'h8000_0000, 5'd3, 2'b11, 5'd10, 1'b1}) begin
      n_err++;
      $display("FAIL srav: v=%b da=%h db=%0d fn=%b rd=%0d sh=%b required 1 80000000 3 11 10 1",
               out_valid, SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift);
    end
    cyc();
  endtask

  task automatic test_nonshift();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h0109_5020;
    rs_data   = 32'h1234_5678;
    rt_data   = 32'hDEAD_BEEF;
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift} !==
        {1'b1, 32'h0, 5'd0, 2'b00, 5'd10, 1'b0}) begin
      n_err++;
      $display("FAIL nonshift: v=%b da=%h db=%0d fn=%b rd=%0d sh=%b required 1 0 0 00 10 0",
               out_valid, SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift);
    end
    // all-zero word is sll $0,$0,0
    in_valid = 1'b1;
    instr    = 32'h0;
    rt_data  = 32'h0000_00AA;
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, SHT_DB, SHT_Func, out_is_shift} !== {1'b1, 5'd0, 2'b01, 1'b1}) begin
      n_err++;
      $display("FAIL nop_sll: v=%b db=%0d fn=%b sh=%b required 1 0 01 1",
               out_valid, SHT_DB, SHT_Func, out_is_shift);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rt_data   = 32'h1;
    instr     = mk_r(5'd0, 5'd1, 5'd1, 5'd1, 6'h00);
    cyc();
    n_cmp++;
    if ({out_valid, in_ready, out_rd} !== {1'b1, 1'b1, 5'd1}) begin
      n_err++;
      $display("FAIL bp_first: v=%b rdy=%b rd=%0d required 1 1 1", out_valid, in_ready, out_rd);
    end
    instr = mk_r(5'd0, 5'd2, 5'd2, 5'd2, 6'h02);
    cyc();
    n_cmp++;
    if ({out_valid, in_ready, out_rd} !== {1'b1, 1'b0, 5'd1}) begin
      n_err++;
      $display("FAIL bp_second: v=%b rdy=%b rd=%0d required 1 0 1", out_valid, in_ready, out_rd);
    end
    instr = mk_r(5'd0, 5'd3, 5'd3, 5'd3, 6'h03);
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, out_rd, stall_cnt} !== {1'b0, 5'd1, 16'd2}) begin
      n_err++;
      $display("FAIL bp_third: rdy=%b rd=%0d cnt=%0d required 0 1 2", in_ready, out_rd, stall_cnt);
    end
    out_ready = 1'b1;
    cyc();
    n_cmp++;
    if ({out_valid, out_rd, SHT_Func, SHT_DB, stall_cnt} !==
        {1'b1, 5'd2, 2'b10, 5'd2, 16'd2}) begin
      n_err++;
      $display("FAIL bp_drain2: v=%b rd=%0d fn=%b db=%0d cnt=%0d required 1 2 10 2 2",
               out_valid, out_rd, SHT_Func, SHT_DB, stall_cnt);
    end
    cyc();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_empty: v=%b rdy=%b required 0 1 (third entry never accepted)",
               out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = mk_r(5'd0, 5'd4, 5'd4, 5'd4, 6'h00);
    cyc();
    instr = mk_r(5'd0, 5'd5, 5'd5, 5'd5, 6'h00);
    cyc();
    flush = 1'b1;
    instr = mk_r(5'd0, 5'd6, 5'd6, 5'd6, 6'h00);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, stall_cnt} !== {1'b0, 1'b1, 16'd2}) begin
      n_err++;
      $display("FAIL flush_full: v=%b rdy=%b cnt=%0d required 0 1 2", out_valid, in_ready, stall_cnt);
    end
    // flush with room available: the simultaneously accepted entry must vanish
    in_valid = 1'b1;
    flush    = 1'b1;
    instr    = mk_r(5'd0, 5'd7, 5'd7, 5'd7, 6'h00);
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_stale: cycle %0d out_valid=%b rd=%0d required 0", k, out_valid, out_rd);
      end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = mk_r(5'd0, 5'd1, 5'd9, 5'd1, 6'h00);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, stall_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL async_reset: v=%b rdy=%b cnt=%0d required 0 1 0", out_valid, in_ready, stall_cnt);
    end
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b1;
    instr    = mk_r(5'd0, 5'd1, 5'd11, 5'd7, 6'h02);
    rt_data  = 32'h0F0F_0F0F;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_release_idle: out_valid=%b required 0", out_valid);
    end
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_rd, SHT_DB, SHT_Func} !== {1'b1, 5'd11, 5'd7, 2'b10}) begin
      n_err++;
      $display("FAIL async_release_accept: v=%b rd=%0d db=%0d fn=%b required 1 11 7 10",
               out_valid, out_rd, SHT_DB, SHT_Func);
    end
    cyc();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t got;
    int   model_cnt;
    logic [5:0] fn_tab [8];
    bit   acc;
    fn_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h05};
    apply_reset();
    model_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(15) == 0);
      rs_data   = $urandom;
      rt_data   = $urandom;
      instr     = $urandom;
      if ($urandom_range(3) != 0) begin
        instr[31:26] = 6'd0;
        instr[5:0]   = fn_tab[$urandom_range(7)];
      end
      n_cmp++;
      if ({in_ready, out_valid} !== {q.size() < 2, q.size() != 0}) begin
        n_err++;
        $display("FAIL rnd_hs @%0d: rdy/valid=%b required %b", i, {in_ready, out_valid},
                 {q.size() < 2, q.size() != 0});
      end
      if (q.size() != 0) begin
        got = {SHT_DA, SHT_DB, SHT_Func, out_rd, out_is_shift};
        n_cmp++;
        if (got !== q[0]) begin
          n_err++;
          $display("FAIL rnd_data @%0d: got %h required %h", i, got, q[0]);
        end
      end
      n_cmp++;
      if (stall_cnt !== 16'(model_cnt)) begin
        n_err++;
        $display("FAIL rnd_stall @%0d: cnt=%0d required %0d", i, stall_cnt, model_cnt);
      end
      // advance the FIFO model with this cycle's inputs
      acc = in_valid && (q.size() < 2);
      if (q.size() != 0 && !out_ready && model_cnt < 65535) model_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(model_decode(instr, rs_data, rt_data));
      end
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sll();
    test_srav();
    test_nonshift();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
